// File: rtl/qdec_pkg.sv
// Shared types and helpers for the quadrature step decoder:
// FSM state encoding, settle timing and transition direction checks.
package qdec_pkg;

  typedef enum logic [2:0] {
    INIT = 3'b100,
    S00  = 3'b000,
    S01  = 3'b001,
    S11  = 3'b011,
    S10  = 3'b010
  } qdec_state_t;

  localparam int unsigned DEF_FILT_LEN = 2;
  localparam int unsigned SETTLE_CYC   = DEF_FILT_LEN + 2;

  function automatic int unsigned settle_cyc(input int unsigned filt_len);
    return filt_len + 2;
  endfunction

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic is_fwd(input logic [1:0] prev, input logic [1:0] next);
    return next == {prev[0], ~prev[1]};
  endfunction

  function automatic logic is_rev(input logic [1:0] prev, input logic [1:0] next);
    return next == {~prev[0], prev[1]};
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder channel bundle: raw A/B inputs towards the decoder,
// step/direction/error results back to the consumer.
interface quad_step_decoder_if #(
  parameter int unsigned ERR_W = 8
);
  logic             a_in;
  logic             b_in;
  logic             step;
  logic             dir;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       ab_state;

  modport master (
    output a_in, b_in,
    input  step, dir, err, err_count, ab_state
  );

  modport slave (
    input  a_in, b_in,
    output step, dir, err, err_count, ab_state
  );
endinterface

// File: rtl/qdec_filter.sv
// One quadrature channel: two-flop synchronizer followed by a glitch filter
// that needs a sustained disagreement before accepting a new level.
module qdec_filter #(
  parameter int unsigned FILT_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic filt_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       filt_q;
  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // The new level is taken on the sample after the counter has reached
  // FILT_LEN, so a pulse lasting FILT_LEN cycles is still rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (sync2_q == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == 4'(FILT_LEN)) begin
      filt_q <= sync2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to step/direction decoder with illegal-jump detection.
// Build macro QDEC_X4_EN: defined = step on every edge (x4), else once per cycle (x1).
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned FILT_LEN = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  quad_step_decoder_if.slave bus
);

  // Filtered inputs only become valid one cycle past the nominal settle time.
  localparam int unsigned SETTLE_LAST = settle_cyc(FILT_LEN) + 1;

  logic             a_filt;
  logic             b_filt;
  logic [1:0]       ab_d;
  logic [1:0]       cur_ab;
  logic             fwd;
  logic             rev;

  qdec_state_t      state_q;
  logic [4:0]       settle_q;
  logic             step_q;
  logic             err_q;
  logic             dir_q;
  logic [ERR_W-1:0] errcnt_q;

  qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk   (clk),
    .rst   (rst),
    .raw_i (bus.a_in),
    .filt_o(a_filt)
  );

  qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk   (clk),
    .rst   (rst),
    .raw_i (bus.b_in),
    .filt_o(b_filt)
  );

  always_comb begin
    ab_d   = {a_filt, b_filt};
    cur_ab = state_q[1:0];
    fwd    = is_fwd(cur_ab, ab_d);
    rev    = is_rev(cur_ab, ab_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      settle_q <= '0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= 1'b1;
      errcnt_q <= '0;
    end else begin
      step_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == INIT) begin
        if (settle_q == 5'(SETTLE_LAST)) begin
          state_q <= qdec_state_t'({1'b0, ab_d});
        end else begin
          settle_q <= settle_q + 5'd1;
        end
      end else if (ab_d != cur_ab) begin
        state_q <= qdec_state_t'({1'b0, ab_d});
        if (fwd || rev) begin
`ifdef QDEC_X4_EN
          step_q <= 1'b1;
          dir_q  <= fwd;
`else
          // Entering S00 forward comes from S10, in reverse from S01.
          if (ab_d == 2'b00) begin
            step_q <= 1'b1;
            dir_q  <= fwd;
          end
`endif
        end else begin
          err_q <= 1'b1;
          if (errcnt_q != '1) begin
            errcnt_q <= errcnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.step      = step_q;
  assign bus.dir       = dir_q;
  assign bus.err       = err_q;
  assign bus.err_count = errcnt_q;
  assign bus.ab_state  = state_q[1:0];

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder (FILT_LEN=2, ERR_W=8), x1 or x4 per QDEC_X4_EN.
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quad_step_decoder_if #(.ERR_W(8)) bus ();

  quad_step_decoder #(.FILT_LEN(2), .ERR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    bit         is_err;
    bit         dir;
    logic [1:0] ab;
    int         cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc      = 0;
  int   tests    = 0;
  int   fails    = 0;
  int   exp_cnt  = 0;
  bit   last_dir = 1'b1;
  bit   prev_dir = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every step/err pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.step) check("dir_stable", int'(bus.dir), int'(prev_dir));
      if (bus.step || bus.err) begin
        check("step_err_excl", int'(bus.step & bus.err), 0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: step=%0b err=%0b at cycle %0d, none expected",
                   bus.step, bus.err, cyc);
        end else begin
          e = q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_is_err", int'(bus.err), int'(e.is_err));
          check("pulse_dir", int'(bus.dir), int'(e.dir));
          check("pulse_ab", int'(bus.ab_state), int'(e.ab));
          if (e.is_err) check("err_count", int'(bus.err_count), e.cnt);
        end
      end
    end
    prev_dir = bus.dir;
  end

  // kind: 0 = no pulse, 1 = step with direction d, 2 = illegal jump.
  task automatic apply(input logic [1:0] ab, input int kind, input bit d);
    @(posedge clk);
    #1;
    bus.a_in = ab[1];
    bus.b_in = ab[0];
    if (kind == 1) begin
      last_dir = d;
      q.push_back('{cyc + 6, 1'b0, d, ab, 0});
    end else if (kind == 2) begin
      if (exp_cnt < 255) exp_cnt++;
      q.push_back('{cyc + 6, 1'b1, last_dir, ab, exp_cnt});
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("ab_state", int'(bus.ab_state), int'(ab));
  endtask

  logic [1:0] seq_ab   [10] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00,
                                2'b10, 2'b11, 2'b01, 2'b00};
`ifdef QDEC_X4_EN
  int         seq_kind [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  localparam int MID_KIND = 1;
`else
  int         seq_kind [10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  localparam int MID_KIND = 0;
`endif
  bit         seq_dir  [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_step", int'(bus.step), 0);
    check("rst_dir", int'(bus.dir), 1);
    check("rst_ab", int'(bus.ab_state), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("init_ab", int'(bus.ab_state), 3);
    check("init_step", int'(bus.step), 0);
    check("init_err", int'(bus.err), 0);
    check("init_dir", int'(bus.dir), 1);
    check("init_err_count", int'(bus.err_count), 0);

    // From 11: 11->10->00, then forward and reverse rotations.
    for (int i = 0; i < 10; i++) apply(seq_ab[i], seq_kind[i], seq_dir[i]);

    // Glitch of 2 cycles on A from S00 is rejected.
    @(posedge clk);
    #1 bus.a_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.a_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch2_ab", int'(bus.ab_state), 0);
    check("glitch2_err_count", int'(bus.err_count), 0);

    // 3-cycle pulse is accepted: 00->10 (reverse) then 10->00 (forward).
    @(posedge clk);
    #1 bus.a_in = 1'b1;
`ifdef QDEC_X4_EN
    q.push_back('{cyc + 6, 1'b0, 1'b0, 2'b10, 0});
`endif
    repeat (3) @(posedge clk);
    #1 bus.a_in = 1'b0;
    q.push_back('{cyc + 6, 1'b0, 1'b1, 2'b00, 0});
    last_dir = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch3_ab", int'(bus.ab_state), 0);

    // Illegal 00<->11 jumps, err_count saturates at 255.
    for (int i = 0; i < 300; i++) apply((i % 2 == 0) ? 2'b11 : 2'b00, 2, 1'b0);
    check("err_count_sat", int'(bus.err_count), 255);
    check("err_dir_held", int'(bus.dir), 1);

    // Reset in the middle of a forward sequence, at S11.
    apply(2'b01, MID_KIND, 1'b1);
    apply(2'b11, MID_KIND, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_step", int'(bus.step), 0);
    check("midrst_err", int'(bus.err), 0);
    check("midrst_dir", int'(bus.dir), 1);
    check("midrst_err_count", int'(bus.err_count), 0);
    check("midrst_ab", int'(bus.ab_state), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("reinit_ab", int'(bus.ab_state), 3);
    check("reinit_err_count", int'(bus.err_count), 0);
    check("reinit_dir", int'(bus.dir), 1);

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
